// File: rtl/uart_boot_loader.sv
// ============================================================================
//  Module   : uart_boot_loader
//  Purpose  : UART program loader writing 16-bit words into the boot BSRAM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_boot_loader #(
  parameter int         CLKS_PER_BIT = 234,
  parameter int         ADDR_W       = 11,
  parameter int         DEPTH        = 2048,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 2700000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              boot_mode,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam int WC_W   = ADDR_W + 1;

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]       DEPTH_L   = 17'(DEPTH);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] F_SYNC   = 3'd0;
  localparam logic [2:0] F_CNT_HI = 3'd1;
  localparam logic [2:0] F_CNT_LO = 3'd2;
  localparam logic [2:0] F_HI     = 3'd3;
  localparam logic [2:0] F_LO     = 3'd4;
  localparam logic [2:0] F_CHK    = 3'd5;
  localparam logic [2:0] F_DONE   = 3'd6;

  // ---------------------------------------------------------------- receiver
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        rx_byte;

  // The shift register is stable while rx_valid is high (receiver is idle).
  assign rx_byte = shift_q;

  always_comb begin
    rx_meta_d   = uart_rx;
    rx_sync_d   = rx_meta_q;
    rx_state_d  = rx_state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          baud_d     = '0;
        end
      end
      RX_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d     = '0;
          bit_idx_d  = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      RX_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      RX_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d      = '0;
          rx_valid_d  = rx_sync_q;
          frame_err_d = ~rx_sync_q;
          rx_state_d  = RX_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ----------------------------------------------------------- frame parser
  logic [2:0]        f_state_q, f_state_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [WC_W-1:0]   n_q, n_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [WC_W-1:0]   word_count_q, word_count_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_wre_q, mem_wre_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic              boot_mode_q, boot_mode_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              in_frame;
  logic              timeout;
  logic [15:0]       n16;
  logic [WC_W-1:0]   wc_next;

  assign in_frame = (f_state_q != F_SYNC) && (f_state_q != F_DONE);
  assign n16      = {cnt_hi_q, rx_byte};
  assign wc_next  = word_count_q + WC_W'(1);

  // rx_valid restarts the idle count, so it always beats a coincident timeout.
  always_comb begin
    timeout = 1'b0;
    idle_d  = '0;
    if (in_frame && !rx_valid_q) begin
      if (idle_q == TO_LAST) begin
        timeout = 1'b1;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
  end

  always_comb begin
    f_state_d    = f_state_q;
    cnt_hi_d     = cnt_hi_q;
    n_d          = n_q;
    hi_d         = hi_q;
    chk_d        = chk_q;
    word_count_d = word_count_q;
    mem_ce_d     = 1'b0;
    mem_wre_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    boot_mode_d  = boot_mode_q;
    done_d       = done_q;
    error_d      = error_q;
    if (in_frame && (frame_err_q || timeout)) begin
      error_d   = 1'b1;
      f_state_d = F_SYNC;
    end else begin
      case (f_state_q)
        F_SYNC: begin
          if (rx_valid_q && (rx_byte == SYNC_BYTE)) begin
            error_d      = 1'b0;
            word_count_d = '0;
            chk_d        = 8'd0;
            mem_addr_d   = '0;
            f_state_d    = F_CNT_HI;
          end
        end
        F_CNT_HI: begin
          if (rx_valid_q) begin
            cnt_hi_d  = rx_byte;
            f_state_d = F_CNT_LO;
          end
        end
        F_CNT_LO: begin
          if (rx_valid_q) begin
            if ((n16 == 16'd0) || ({1'b0, n16} > DEPTH_L)) begin
              error_d   = 1'b1;
              f_state_d = F_SYNC;
            end else begin
              n_d       = n16[WC_W-1:0];
              f_state_d = F_HI;
            end
          end
        end
        F_HI: begin
          if (rx_valid_q) begin
            hi_d      = rx_byte;
            chk_d     = chk_q + rx_byte;
            f_state_d = F_LO;
          end
        end
        F_LO: begin
          // Write pulse happens first, the count advances on the cycle after.
          if (mem_wre_q) begin
            word_count_d = wc_next;
            f_state_d    = (wc_next == n_q) ? F_CHK : F_HI;
          end else if (rx_valid_q) begin
            chk_d      = chk_q + rx_byte;
            mem_din_d  = {hi_q, rx_byte};
            mem_addr_d = word_count_q[ADDR_W-1:0];
            mem_ce_d   = 1'b1;
            mem_wre_d  = 1'b1;
          end
        end
        F_CHK: begin
          if (rx_valid_q) begin
            if (rx_byte == chk_q) begin
              done_d      = 1'b1;
              boot_mode_d = 1'b0;
              f_state_d   = F_DONE;
            end else begin
              error_d   = 1'b1;
              f_state_d = F_SYNC;
            end
          end
        end
        F_DONE: f_state_d = F_DONE;
        default: f_state_d = F_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state_q    <= F_SYNC;
      cnt_hi_q     <= 8'd0;
      n_q          <= '0;
      hi_q         <= 8'd0;
      chk_q        <= 8'd0;
      idle_q       <= '0;
      word_count_q <= '0;
      mem_ce_q     <= 1'b0;
      mem_wre_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= 16'd0;
      boot_mode_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      f_state_q    <= f_state_d;
      cnt_hi_q     <= cnt_hi_d;
      n_q          <= n_d;
      hi_q         <= hi_d;
      chk_q        <= chk_d;
      idle_q       <= idle_d;
      word_count_q <= word_count_d;
      mem_ce_q     <= mem_ce_d;
      mem_wre_q    <= mem_wre_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      boot_mode_q  <= boot_mode_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_ce     = mem_ce_q;
  assign mem_wre    = mem_wre_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign boot_mode  = boot_mode_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
// ============================================================================
//  Module   : tb_uart_boot_loader
//  Purpose  : Directed frame vectors plus reset/glitch sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_boot_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        mem_ce, mem_wre, boot_mode, done, error;
  logic [10:0] mem_addr;
  logic [15:0] mem_din;
  logic [11:0] word_count;

  int checks = 0;
  int errors = 0;
  logic [26:0] wr_q[$];

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (11),
    .DEPTH       (2048),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .mem_ce    (mem_ce),
    .mem_wre   (mem_wre),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .boot_mode (boot_mode),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          bad_stop;
    int          glitch_at;
    int          tail;
    int          nwr;
    logic [26:0] w0;
    logic [26:0] w1;
    logic        err;
    logic        dn;
    logic        boot;
    logic [11:0] wc;
    logic        chk_sync;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write pulse must have ce with it and happen only while booting.
  always @(negedge clk) begin
    if (!rst && (mem_wre || mem_ce)) begin
      check("ce_wre_boot", {29'd0, mem_ce, mem_wre, boot_mode}, 32'h7);
      wr_q.push_back({mem_addr, mem_din});
    end
  end

  function automatic logic [63:0] pk8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic glitch();
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ce"},   32'(mem_ce),     32'd0);
    check({tag, "_wre"},  32'(mem_wre),    32'd0);
    check({tag, "_addr"}, 32'(mem_addr),   32'd0);
    check({tag, "_din"},  32'(mem_din),    32'd0);
    check({tag, "_boot"}, 32'(boot_mode),  32'd1);
    check({tag, "_done"}, 32'(done),       32'd0);
    check({tag, "_err"},  32'(error),      32'd0);
    check({tag, "_wc"},   32'(word_count), 32'd0);
  endtask

  task automatic run_vec(input int k);
    vec_t  v;
    string t;
    v = vecs[k];
    t = $sformatf("vec%0d", k);
    wr_q.delete();
    for (int i = 0; i < v.n; i++) begin
      if (i == v.glitch_at) glitch();
      send_byte(v.bytes[8*i +: 8], (i == v.bad_stop) ? 1'b0 : 1'b1);
      if (i == 0 && v.chk_sync) begin
        check({t, "_sync_err"}, 32'(error),      32'd0);
        check({t, "_sync_wc"},  32'(word_count), 32'd0);
      end
    end
    repeat (v.tail + 10) @(negedge clk);
    check({t, "_nwr"}, 32'(wr_q.size()), 32'(v.nwr));
    if (v.nwr > 0 && wr_q.size() > 0) check({t, "_w0"}, 32'(wr_q[0]), 32'(v.w0));
    if (v.nwr > 1 && wr_q.size() > 1) check({t, "_w1"}, 32'(wr_q[1]), 32'(v.w1));
    check({t, "_err"},  32'(error),      32'(v.err));
    check({t, "_done"}, 32'(done),       32'(v.dn));
    check({t, "_boot"}, 32'(boot_mode),  32'(v.boot));
    check({t, "_wc"},   32'(word_count), 32'(v.wc));
  endtask

  initial begin
    // n, bytes, bad_stop, glitch_at, tail, nwr, w0, w1, err, done, boot, wc, chk_sync
    vecs[0] = '{3, pk8(8'hA5, 8'h00, 8'h00, 0, 0, 0, 0, 0), -1, -1, 0,
                0, 27'd0, 27'd0, 1'b1, 1'b0, 1'b1, 12'd0, 1'b1};
    vecs[1] = '{3, pk8(8'hA5, 8'h08, 8'h01, 0, 0, 0, 0, 0), -1, -1, 0,
                0, 27'd0, 27'd0, 1'b1, 1'b0, 1'b1, 12'd0, 1'b1};
    vecs[2] = '{3, pk8(8'hA5, 8'h00, 8'h03, 0, 0, 0, 0, 0), -1, -1, 250,
                0, 27'd0, 27'd0, 1'b1, 1'b0, 1'b1, 12'd0, 1'b1};
    vecs[3] = '{5, pk8(8'hA5, 8'h00, 8'h02, 8'h00, 8'hA1, 0, 0, 0), 4, -1, 20,
                0, 27'd0, 27'd0, 1'b1, 1'b0, 1'b1, 12'd0, 1'b1};
    vecs[4] = '{6, pk8(8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00, 0, 0), -1, -1, 0,
                1, {11'd0, 16'h1234}, 27'd0, 1'b1, 1'b0, 1'b1, 12'd1, 1'b1};
    vecs[5] = '{6, pk8(8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h46, 0, 0), -1, 3, 0,
                1, {11'd0, 16'h1234}, 27'd0, 1'b0, 1'b1, 1'b0, 12'd1, 1'b1};
    vecs[6] = '{8, pk8(8'hA5, 8'h00, 8'h02, 8'h00, 8'hA1, 8'h00, 8'h78, 8'h19), -1, -1, 0,
                2, {11'd0, 16'h00A1}, {11'd1, 16'h0078}, 1'b0, 1'b1, 1'b0, 12'd2, 1'b1};
    vecs[7] = '{6, pk8(8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h46, 0, 0), -1, -1, 0,
                0, 27'd0, 27'd0, 1'b0, 1'b1, 1'b0, 12'd2, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Idle-line glitch must not produce a byte or an error.
    wr_q.delete();
    glitch();
    repeat (20) @(negedge clk);
    check("glitch_err", 32'(error), 32'd0);
    check("glitch_nwr", 32'(wr_q.size()), 32'd0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Async reset out of the loaded state.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_done");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Async reset in the middle of the second word of a frame.
    wr_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA1, 1'b1);
    check("mid_wc", 32'(word_count), 32'd1);
    check("mid_din", 32'(mem_din), 32'h00A1);
    send_byte(8'h00, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    run_vec(6);
    run_vec(7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
